rmii_rx: RTL

//   RMII receive front end of the Ethernet MAC (100 Mb/s, 50 MHz RMII ref clock, one dibit per clock).

---
 rtl/rmii_rx.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rmii_rx.sv
// RMII receive front end: turns the PHY dibit stream into bytes, stripping preamble/SFD,
// following CRS_DV toggling at frame end, and reporting FCS, length and PHY errors on the last byte.
module rmii_rx #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_PRE = 4
) (
  input  logic        clk_mac,
  input  logic        rst,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  input  logic        eth_rxerr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [3:0]  rx_status,
  output logic [10:0] rx_len
);

  localparam logic [10:0] MinLen  = 11'(MIN_LEN);
  localparam logic [10:0] MaxLen  = 11'(MAX_LEN);
  localparam logic [3:0]  MinPre  = 4'(MIN_PRE);
  localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPoly = 32'hEDB8_8320;
  localparam logic [31:0] CrcGood = 32'hDEBB_20E3;

  typedef enum logic [1:0] {StDrop, StIdle, StPre, StData} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  pos_q, pos_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  buf_q, buf_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_byte_q, crc_byte_d;
  logic        phy_err_q, phy_err_d;
  logic        last_dv_q, last_dv_d;

  logic [7:0]  rx_data_d;
  logic        rx_valid_d, rx_sof_d, rx_eof_d;
  logic [3:0]  rx_status_d;
  logic [10:0] rx_len_d;

  logic [7:0]  byte_new;
  logic [31:0] crc_next;
  logic        dribble;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c_in, input logic [1:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 2; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ CrcPoly;
    end
    return c;
  endfunction

  assign byte_new = {eth_rxd, sr_q[7:2]};
  assign crc_next = crc_dibit(crc_q, eth_rxd);
  // Partial dibits survive unless the only one (p=0) was a discarded tentative dibit.
  assign dribble  = (pos_q == 2'd3) || (pos_q == 2'd1 && last_dv_q);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    pos_d       = pos_q;
    sr_d        = sr_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    crc_byte_d  = crc_byte_q;
    phy_err_d   = phy_err_q;
    last_dv_d   = last_dv_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    rx_sof_d    = 1'b0;
    rx_eof_d    = 1'b0;
    rx_status_d = 4'd0;
    rx_len_d    = 11'd0;

    unique case (state_q)
      StDrop: begin
        if (!eth_crsdv) state_d = StIdle;
      end
      StIdle: begin
        if (eth_crsdv && eth_rxd == 2'b01) begin
          state_d   = StPre;
          pre_cnt_d = 4'd1;
          phy_err_d = 1'b0;
        end
      end
      StPre: begin
        if (!eth_crsdv) begin
          state_d = StIdle;
        end else begin
          if (eth_rxerr) phy_err_d = 1'b1;
          if (eth_rxd == 2'b01) begin
            if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (eth_rxd == 2'b11 && pre_cnt_q >= MinPre) begin
            state_d   = StData;
            pos_d     = 2'd0;
            cnt_d     = 11'd0;
            crc_d     = CrcInit;
            last_dv_d = 1'b1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StData: begin
        if (eth_rxerr) phy_err_d = 1'b1;
        sr_d      = byte_new;
        crc_d     = crc_next;
        pos_d     = pos_q + 2'd1;
        last_dv_d = eth_crsdv;
        if (!eth_crsdv && pos_q[0]) begin
          state_d = StIdle;
          if (cnt_q != 11'd0) begin
            rx_valid_d  = 1'b1;
            rx_data_d   = buf_q;
            rx_sof_d    = (cnt_q == 11'd1);
            rx_eof_d    = 1'b1;
            rx_status_d = {cnt_q < MinLen, dribble, crc_byte_q != CrcGood, phy_err_d};
            rx_len_d    = cnt_q;
          end
        end else if (pos_q == 2'd3) begin
          crc_byte_d = crc_next;
          buf_d      = byte_new;
          if (cnt_q == MaxLen) begin
            // Oversize: close the frame on the buffered byte and ignore the rest.
            state_d     = StDrop;
            rx_valid_d  = 1'b1;
            rx_data_d   = buf_q;
            rx_sof_d    = (cnt_q == 11'd1);
            rx_eof_d    = 1'b1;
            rx_status_d = {1'b1, 1'b0, 1'b0, phy_err_d};
            rx_len_d    = MaxLen;
          end else begin
            cnt_d = cnt_q + 11'd1;
            if (cnt_q != 11'd0) begin
              rx_valid_d = 1'b1;
              rx_data_d  = buf_q;
              rx_sof_d   = (cnt_q == 11'd1);
            end
          end
        end
      end
      default: state_d = StDrop;
    endcase
  end

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      state_q    <= StDrop;
      pre_cnt_q  <= 4'd0;
      pos_q      <= 2'd0;
      sr_q       <= 8'd0;
      buf_q      <= 8'd0;
      cnt_q      <= 11'd0;
      crc_q      <= CrcInit;
      crc_byte_q <= CrcInit;
      phy_err_q  <= 1'b0;
      last_dv_q  <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_err     <= 1'b0;
      rx_status  <= 4'd0;
      rx_len     <= 11'd0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      pos_q      <= pos_d;
      sr_q       <= sr_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      crc_byte_q <= crc_byte_d;
      phy_err_q  <= phy_err_d;
      last_dv_q  <= last_dv_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      rx_sof     <= rx_sof_d;
      rx_eof     <= rx_eof_d;
      rx_err     <= |rx_status_d;
      rx_status  <= rx_status_d;
      rx_len     <= rx_len_d;
    end
  end

endmodule
